// File: rtl/q_add8_pkg.sv
// rtl/q_add8_pkg.sv - shared types and constants for the quantized add sequencer
package q_add8_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam int DP_LAT_DEF   = 8;
    localparam int WD_SLACK_DEF = 4;

    // Longest legal DRAIN: full datapath latency, the read-to-input register, plus slack.
    function automatic int wd_limit(input int dp_lat, input int slack);
        return dp_lat + 1 + slack;
    endfunction

endpackage

// File: rtl/q_add8_seq_if.sv
// rtl/q_add8_seq_if.sv - buffer and datapath signals between sequencer and add datapath
interface q_add8_seq_if #(
    parameter int ADDR_W = 12
);
    logic              A_RD_EN;
    logic [ADDR_W-1:0] A_RD_ADDR;
    logic [7:0]        A_RD_DATA;
    logic              B_RD_EN;
    logic [ADDR_W-1:0] B_RD_ADDR;
    logic [7:0]        B_RD_DATA;
    logic              DP_INPUT_EN;
    logic [7:0]        DP_A;
    logic [7:0]        DP_B;
    logic [31:0]       DP_GAIN;
    logic [31:0]       DP_Q_PARAM;
    logic              DP_OUTPUT_EN;
    logic [7:0]        DP_C;
    logic              C_WR_EN;
    logic [ADDR_W-1:0] C_WR_ADDR;
    logic [7:0]        C_WR_DATA;

    modport master (
        output A_RD_EN, A_RD_ADDR, B_RD_EN, B_RD_ADDR,
        output DP_INPUT_EN, DP_A, DP_B, DP_GAIN, DP_Q_PARAM,
        output C_WR_EN, C_WR_ADDR, C_WR_DATA,
        input  A_RD_DATA, B_RD_DATA, DP_OUTPUT_EN, DP_C
    );

    modport slave (
        input  A_RD_EN, A_RD_ADDR, B_RD_EN, B_RD_ADDR,
        input  DP_INPUT_EN, DP_A, DP_B, DP_GAIN, DP_Q_PARAM,
        input  C_WR_EN, C_WR_ADDR, C_WR_DATA,
        output A_RD_DATA, B_RD_DATA, DP_OUTPUT_EN, DP_C
    );

endinterface

// File: rtl/q_add8_addr_gen.sv
// rtl/q_add8_addr_gen.sv - base plus element counter address generator with last-element compare
module q_add8_addr_gen #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET_X,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Truncating the counter gives the modulo-buffer wrap for free.
    assign o_addr = i_base + r_cnt[ADDR_W-1:0];
    assign o_last = (r_cnt == i_len - 1'b1);

endmodule

// File: rtl/q_add8_seq.sv
// rtl/q_add8_seq.sv - streams one vector-add job through the quantized add datapath
module q_add8_seq
    import q_add8_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int LEN_W    = 16,
    parameter int DP_LAT   = DP_LAT_DEF,
    parameter int WD_SLACK = WD_SLACK_DEF
) (
    input  logic              CLK,
    input  logic              RESET_X,
    input  logic              START,
    input  logic              ABORT,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [ADDR_W-1:0] A_BASE,
    input  logic [ADDR_W-1:0] B_BASE,
    input  logic [ADDR_W-1:0] C_BASE,
    input  logic [31:0]       GAIN_CFG,
    input  logic [31:0]       QP_CFG,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    q_add8_seq_if.master      bus
);

    localparam int TMR_W = 8;
    localparam logic [TMR_W-1:0] WD_LIM    = TMR_W'(wd_limit(DP_LAT, WD_SLACK));
    localparam logic [TMR_W-1:0] FLUSH_END = TMR_W'(DP_LAT);

    state_e            r_state;
    state_e            w_state_nx;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic [ADDR_W-1:0] r_c_base;
    logic [31:0]       r_gain;
    logic [31:0]       r_qp;
    logic              r_err;
    logic              r_in_en;
    logic [TMR_W-1:0]  r_tmr;

    logic              w_accept;
    logic              w_rd_en;
    logic              w_wr_en;
    logic              w_rd_last;
    logic              w_wr_last;
    logic              w_wr_final;
    logic              w_wd_fire;
    logic [ADDR_W-1:0] w_a_addr;
    logic [ADDR_W-1:0] w_c_addr;

    assign w_accept   = (r_state == IDLE) && START;
    assign w_rd_en    = (r_state == ISSUE) && !ABORT;
    assign w_wr_en    = bus.DP_OUTPUT_EN && ((r_state == ISSUE) || (r_state == DRAIN));
    assign w_wr_final = w_wr_en && w_wr_last;
    assign w_wd_fire  = (r_state == DRAIN) && !ABORT && !w_wr_final && (r_tmr >= WD_LIM);

    q_add8_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
        .CLK     (CLK),
        .RESET_X (RESET_X),
        .i_clr   (w_accept),
        .i_inc   (w_rd_en),
        .i_base  (r_a_base),
        .i_len   (r_len),
        .o_addr  (w_a_addr),
        .o_last  (w_rd_last)
    );

    q_add8_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
        .CLK     (CLK),
        .RESET_X (RESET_X),
        .i_clr   (w_accept),
        .i_inc   (w_wr_en),
        .i_base  (r_c_base),
        .i_len   (r_len),
        .o_addr  (w_c_addr),
        .o_last  (w_wr_last)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nx = (LEN == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (ABORT) begin
                    w_state_nx = FLUSH;
                end else if (w_rd_last) begin
                    w_state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (ABORT) begin
                    w_state_nx = FLUSH;
                end else if (w_wr_final || w_wd_fire) begin
                    w_state_nx = FIN;
                end
            end
            FLUSH: begin
                if (r_tmr == FLUSH_END) begin
                    w_state_nx = IDLE;
                end
            end
            FIN:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
            r_gain   <= '0;
            r_qp     <= '0;
            r_err    <= 1'b0;
            r_in_en  <= 1'b0;
            r_tmr    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_in_en <= w_rd_en;
            // One timer serves both DRAIN watchdog and FLUSH length; it restarts on every state change.
            r_tmr   <= (w_state_nx != r_state) ? '0 : r_tmr + 1'b1;
            if (w_accept) begin
                r_len    <= LEN;
                r_a_base <= A_BASE;
                r_b_base <= B_BASE;
                r_c_base <= C_BASE;
                r_gain   <= GAIN_CFG;
                r_qp     <= QP_CFG;
                r_err    <= 1'b0;
            end else if (w_wd_fire) begin
                r_err <= 1'b1;
            end
        end
    end

    // A and B counters move in lockstep, so B reuses the A offset.
    assign bus.A_RD_EN    = w_rd_en;
    assign bus.B_RD_EN    = w_rd_en;
    assign bus.A_RD_ADDR  = w_a_addr;
    assign bus.B_RD_ADDR  = r_b_base + (w_a_addr - r_a_base);
    assign bus.DP_INPUT_EN = r_in_en;
    assign bus.DP_A       = bus.A_RD_DATA;
    assign bus.DP_B       = bus.B_RD_DATA;
    assign bus.DP_GAIN    = r_gain;
    assign bus.DP_Q_PARAM = r_qp;
    assign bus.C_WR_EN    = w_wr_en;
    assign bus.C_WR_ADDR  = w_c_addr;
    assign bus.C_WR_DATA  = bus.DP_C;

    assign BUSY = (r_state != IDLE);
    assign DONE = (r_state == FIN);
    assign ERR  = r_err;

endmodule

// File: tb/tb_q_add8_seq.sv
// tb/tb_q_add8_seq.sv - directed self-checking bench for q_add8_seq
module tb_q_add8_seq;

    logic        CLK = 1'b0;
    logic        RESET_X;
    logic        START;
    logic        ABORT;
    logic [15:0] LEN;
    logic [11:0] A_BASE;
    logic [11:0] B_BASE;
    logic [11:0] C_BASE;
    logic [31:0] GAIN_CFG;
    logic [31:0] QP_CFG;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    q_add8_seq_if #(.ADDR_W(12)) bus ();

    q_add8_seq dut (
        .CLK      (CLK),
        .RESET_X  (RESET_X),
        .START    (START),
        .ABORT    (ABORT),
        .LEN      (LEN),
        .A_BASE   (A_BASE),
        .B_BASE   (B_BASE),
        .C_BASE   (C_BASE),
        .GAIN_CFG (GAIN_CFG),
        .QP_CFG   (QP_CFG),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  amem [4096];
    logic [7:0]  bmem [4096];
    logic [7:0]  cmem [4096];
    logic        pe   [8];
    logic [7:0]  pc   [8];
    int          in_cnt;
    int          drop_idx = -1;

    function automatic logic [7:0] dp_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [31:0] g, input logic [31:0] q);
        logic [31:0] t;
        t = ({24'd0, b} * g + {24'd0, a}) * q;
        return t[7:0];
    endfunction

    always @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            bus.A_RD_DATA <= 8'd0;
            bus.B_RD_DATA <= 8'd0;
            in_cnt        <= 0;
            for (int i = 0; i < 8; i++) begin
                pe[i] <= 1'b0;
                pc[i] <= 8'd0;
            end
        end else begin
            if (bus.A_RD_EN) bus.A_RD_DATA <= amem[bus.A_RD_ADDR];
            if (bus.B_RD_EN) bus.B_RD_DATA <= bmem[bus.B_RD_ADDR];
            if (START) in_cnt <= 0;
            else if (bus.DP_INPUT_EN) in_cnt <= in_cnt + 1;
            pe[0] <= bus.DP_INPUT_EN && (in_cnt != drop_idx);
            pc[0] <= dp_fn(bus.DP_A, bus.DP_B, bus.DP_GAIN, bus.DP_Q_PARAM);
            for (int i = 1; i < 8; i++) begin
                pe[i] <= pe[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end

    assign bus.DP_OUTPUT_EN = pe[7];
    assign bus.DP_C         = pc[7];

    always @(posedge CLK) begin
        if (bus.C_WR_EN) cmem[bus.C_WR_ADDR] <= bus.C_WR_DATA;
    end

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] rd_m, in_m, wr_m, busy_m, done_m, err_m;
    logic [11:0] a_log [64];
    logic [11:0] b_log [64];
    logic [31:0] g_log [64];
    logic [31:0] q_log [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // START was driven in cycle 0; records cycles 1..n, sampling after the falling edge.
    task automatic observe(input int n, input int abort_at, input int re1, input int re2);
        rd_m = '0; in_m = '0; wr_m = '0; busy_m = '0; done_m = '0; err_m = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            START = (k == re1) || (k == re2);
            if (k == re1) begin GAIN_CFG = 32'd7; QP_CFG = 32'd9; end
            if (k == re2) begin GAIN_CFG = 32'd4; QP_CFG = 32'd1; C_BASE = 12'h070; end
            ABORT = (k == abort_at);
            #1;
            rd_m[k]   = bus.A_RD_EN;
            in_m[k]   = bus.DP_INPUT_EN;
            wr_m[k]   = bus.C_WR_EN;
            busy_m[k] = BUSY;
            done_m[k] = DONE;
            err_m[k]  = ERR;
            a_log[k]  = bus.A_RD_ADDR;
            b_log[k]  = bus.B_RD_ADDR;
            g_log[k]  = bus.DP_GAIN;
            q_log[k]  = bus.DP_Q_PARAM;
        end
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    initial begin
        RESET_X = 1'b0; START = 1'b0; ABORT = 1'b0; LEN = '0;
        A_BASE = '0; B_BASE = '0; C_BASE = '0; GAIN_CFG = '0; QP_CFG = '0;
        for (int i = 0; i < 4096; i++) begin
            amem[i] = 8'd0; bmem[i] = 8'd0; cmem[i] = 8'd0;
        end
        amem[12'h010] = 8'h11; amem[12'h011] = 8'h22; amem[12'h012] = 8'h33; amem[12'h013] = 8'h44;
        bmem[12'h020] = 8'h01; bmem[12'h021] = 8'h02; bmem[12'h022] = 8'h03; bmem[12'h023] = 8'hF0;
        amem[12'h040] = 8'h05; amem[12'h041] = 8'h10;
        bmem[12'h050] = 8'h07; bmem[12'h051] = 8'h01;
        repeat (3) @(negedge CLK);
        RESET_X = 1'b1;
        #1;
        chk("reset_outputs", {BUSY, DONE, ERR, bus.A_RD_EN, bus.B_RD_EN, bus.DP_INPUT_EN, bus.C_WR_EN}, 64'd0);
        chk("reset_coef", {bus.DP_GAIN, bus.DP_Q_PARAM}, 64'd0);

        // Basic LEN=4 job, gain=1 qp=1 so c = a + b
        @(negedge CLK);
        LEN = 16'd4; A_BASE = 12'h010; B_BASE = 12'h020; C_BASE = 12'h030;
        GAIN_CFG = 32'd1; QP_CFG = 32'd1; START = 1'b1;
        observe(16, 0, 0, 0);
        chk("j1_reads", rd_m, 64'h1E);
        chk("j1_input_en", in_m, 64'h3C);
        chk("j1_writes", wr_m, 64'h3C00);
        chk("j1_done", done_m, 64'h4000);
        chk("j1_busy", busy_m, 64'h7FFE);
        chk("j1_a_addr_first", a_log[1], 64'h010);
        chk("j1_a_addr_last", a_log[4], 64'h013);
        chk("j1_b_addr_last", b_log[4], 64'h023);
        chk("j1_c0", cmem[12'h030], 64'h12);
        chk("j1_c1", cmem[12'h031], 64'h24);
        chk("j1_c2", cmem[12'h032], 64'h36);
        chk("j1_c3", cmem[12'h033], 64'h34);

        // LEN=0 goes straight to FIN
        @(negedge CLK);
        LEN = 16'd0; START = 1'b1;
        observe(4, 0, 0, 0);
        chk("len0_busy", busy_m, 64'h2);
        chk("len0_done", done_m, 64'h2);
        chk("len0_strobes", rd_m | wr_m | in_m, 64'h0);

        // Read address wrap at top of buffer
        @(negedge CLK);
        LEN = 16'd4; A_BASE = 12'hFFE; B_BASE = 12'h100; C_BASE = 12'h200; START = 1'b1;
        observe(16, 0, 0, 0);
        chk("wrap_addr2", a_log[2], 64'hFFF);
        chk("wrap_addr3", a_log[3], 64'h000);
        chk("wrap_addr4", a_log[4], 64'h001);
        chk("wrap_no_err", err_m, 64'h0);
        chk("wrap_done", done_m, 64'h4000);

        // ABORT in cycle 3 of a LEN=16 job
        @(negedge CLK);
        LEN = 16'd16; A_BASE = 12'h010; B_BASE = 12'h020; C_BASE = 12'h300; START = 1'b1;
        observe(16, 3, 0, 0);
        chk("abort_reads", rd_m, 64'h6);
        chk("abort_writes", wr_m, 64'h0);
        chk("abort_done", done_m, 64'h0);
        chk("abort_busy", busy_m, 64'h1FFE);

        // One datapath output dropped: watchdog ends the job
        @(negedge CLK);
        drop_idx = 3;
        LEN = 16'd8; A_BASE = 12'h010; B_BASE = 12'h020; C_BASE = 12'h400; START = 1'b1;
        observe(26, 0, 0, 0);
        drop_idx = -1;
        chk("wd_writes", wr_m, 64'h3DC00);
        chk("wd_done", done_m, 64'h800000);
        chk("wd_err", err_m, 64'h7800000);
        chk("wd_busy", busy_m, 64'hFFFFFE);

        // Back-to-back: START while busy is ignored, START after DONE is accepted
        @(negedge CLK);
        LEN = 16'd2; A_BASE = 12'h040; B_BASE = 12'h050; C_BASE = 12'h060;
        GAIN_CFG = 32'd2; QP_CFG = 32'd3; START = 1'b1;
        observe(27, 0, 5, 13);
        chk("b2b_err_cleared", err_m[1], 64'h0);
        chk("b2b_done", done_m, 64'h2001000);
        chk("b2b_busy", busy_m, 64'h3FFDFFE);
        chk("b2b_gain_held", g_log[12], 64'd2);
        chk("b2b_gain_idle", g_log[13], 64'd2);
        chk("b2b_gain_new", g_log[14], 64'd4);
        chk("b2b_qp_new", q_log[14], 64'd1);
        chk("b2b_j1_c0", cmem[12'h060], 64'h39);
        chk("b2b_j1_c1", cmem[12'h061], 64'h36);
        chk("b2b_j2_c0", cmem[12'h070], 64'h21);
        chk("b2b_j2_c1", cmem[12'h071], 64'h14);

        // Reset mid-job drops strobes immediately
        @(negedge CLK);
        LEN = 16'd8; A_BASE = 12'h010; B_BASE = 12'h020; C_BASE = 12'h500; START = 1'b1;
        observe(3, 0, 0, 0);
        chk("midrst_reads_before", rd_m, 64'hE);
        RESET_X = 1'b0;
        #1;
        chk("midrst_outputs", {BUSY, DONE, bus.A_RD_EN, bus.DP_INPUT_EN, bus.C_WR_EN}, 64'd0);
        @(negedge CLK);
        RESET_X = 1'b1;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/q_add8_seq.md
Name: q_add8_seq

Overview:
- Sequencer that streams one vector-add job through the 8-bit quantized add datapath (c = (b*gain + a) * q_param).
- Reads operand vectors A and B from two single-port input buffers, feeds the datapath and holds its GAIN/Q_PARAM stable.
- Writes each datapath result into an output buffer and signals job completion.
- Sits between the NPU layer controller (config/start) and the add datapath plus its three SRAMs.

Parameters:
- ADDR_W, 12, buffer address width; all address arithmetic is modulo 2^ADDR_W.
- LEN_W, 16, width of the job length field.
- DP_LAT, 8, fixed datapath latency in cycles, from INPUT_EN to OUTPUT_EN.
- WD_SLACK, 4, extra drain cycles allowed before the watchdog error fires.

Ports:
- CLK  in  1  clock.
- RESET_X  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle job start; sampled only in IDLE.
- ABORT  in  1  synchronous job cancel.
- LEN  in  LEN_W  number of elements in the job.
- A_BASE / B_BASE / C_BASE  in  ADDR_W each  buffer base addresses.
- GAIN_CFG / QP_CFG  in  32 each  job gain and quantization parameter.
- BUSY  out  1  high from the cycle after START until return to IDLE.
- DONE  out  1  one-cycle pulse at normal job end.
- ERR  out  1  sticky watchdog flag; cleared by the next accepted START.
- A_RD_EN / B_RD_EN  out  1  input buffer read strobes.
- A_RD_ADDR / B_RD_ADDR  out  ADDR_W  read addresses.
- A_RD_DATA / B_RD_DATA  in  8  read data, valid 1 cycle after the strobe.
- DP_INPUT_EN  out  1  datapath input valid.
- DP_A / DP_B  out  8  datapath operands.
- DP_GAIN / DP_Q_PARAM  out  32  datapath coefficients.
- DP_OUTPUT_EN  in  1  datapath result valid.
- DP_C  in  8  datapath result.
- C_WR_EN  out  1  output buffer write strobe.
- C_WR_ADDR  out  ADDR_W  output buffer write address.
- C_WR_DATA  out  8  output buffer write data.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; DP_GAIN and DP_Q_PARAM 0.
- States are IDLE, ISSUE, DRAIN, FLUSH and FIN.
- IDLE:
  - START=1 latches LEN, the three base addresses, GAIN_CFG and QP_CFG, and clears ERR.
  - Next state is ISSUE, or FIN when LEN=0.
  - START in any other state is ignored.
- ISSUE:
  - Each cycle asserts A_RD_EN and B_RD_EN with addresses base+rd_cnt, then increments rd_cnt.
  - After the cycle with rd_cnt=LEN-1, moves to DRAIN.
  - Issue never stalls; one element per cycle.
- Operand path:
  - DP_INPUT_EN is A_RD_EN delayed by one register.
  - DP_A and DP_B are A_RD_DATA and B_RD_DATA passed through combinationally.
  - DP_GAIN and DP_Q_PARAM are registered at START and held constant until the next accepted START.
- Writeback:
  - On DP_OUTPUT_EN=1 the block asserts C_WR_EN in the same cycle, with C_WR_ADDR=C_BASE+wr_cnt and C_WR_DATA=DP_C, then increments wr_cnt.
  - DP_OUTPUT_EN is honoured in ISSUE and DRAIN; it is ignored (no write) in IDLE, FLUSH and FIN.
- DRAIN:
  - When wr_cnt reaches LEN, moves to FIN.
  - A watchdog counts DRAIN cycles. When the count exceeds DP_LAT+1+WD_SLACK, the block sets ERR and moves to FIN.
- FIN: DONE=1 for exactly one cycle, BUSY=0 from the next cycle, then IDLE.
- ABORT (in ISSUE or DRAIN):
  - Reads stop that same cycle and the block enters FLUSH.
  - FLUSH lasts DP_LAT+1 cycles with writes suppressed, then IDLE with no DONE pulse.
  - ABORT in IDLE or FIN has no effect.
  - ABORT wins over a simultaneous final-write transition.
- Timing for LEN=N with START high at edge t:
  - Reads are issued in cycles t+1..t+N.
  - DP_INPUT_EN is high t+2..t+N+1.
  - Writes occur t+2+DP_LAT .. t+1+DP_LAT+N.
  - DONE is high in cycle t+2+DP_LAT+N.
- Address wrap: a base near the top of the buffer wraps modulo 2^ADDR_W with no error.
- Counters are LEN_W wide. LEN=2^LEN_W-1 must complete without counter overflow.
- Reset asserted mid-job immediately returns the block to IDLE with all strobes low.

Decomposition:
- Package q_add8_pkg:
  - state enum (IDLE, ISSUE, DRAIN, FLUSH, FIN);
  - DP_LAT_DEF=8;
  - the watchdog limit expression.
- One natural sub-module, q_add8_addr_gen: base+counter address generator with done compare. It is instantiated twice: once for the shared A/B read side (the A and B counters are equal) and once for the C write side.
- FSM, delay register and watchdog stay in the top module.

Test Plan:
- LEN=4, A_BASE=0x010, B_BASE=0x020, C_BASE=0x030, START at t0, datapath model with 8-cycle delay:
  - reads at t0+1..t0+4;
  - writes to 0x030..0x033 at t0+10..t0+13;
  - DONE high only at t0+14; BUSY t0+1..t0+14.
- LEN=0 START -> BUSY one cycle, DONE at t0+1, no read or write strobes.
- A_BASE=0xFFE, LEN=4 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001; no ERR.
- ABORT at t0+3 of a LEN=16 job:
  - no read strobe from t0+3;
  - no C_WR_EN through FLUSH (9 cycles);
  - IDLE afterwards, DONE never asserted.
- Datapath model drops one OUTPUT_EN on a LEN=8 job:
  - 7 writes;
  - watchdog fires after 13 DRAIN cycles; ERR=1, DONE pulses;
  - the next START clears ERR.
- Back-to-back jobs with START re-asserted during BUSY (ignored), then on the cycle after DONE (accepted):
  - GAIN/Q_PARAM change only at acceptance;
  - second job results written correctly.
